svo_sprite_gen: RTL and testbench
=================================

SVO_SPRITE_GEN -- requirements
Module: svo_sprite_gen

Interface
REQ-001 The block SHALL have parameter SVO_HOR_PIXELS, default 640, active pixels per line.
REQ-002 The block SHALL have parameter SVO_VER_PIXELS, default 480, active lines per frame.
REQ-003 The block SHALL have parameter SVO_BITS_PER_PIXEL, default 24, output pixel width.
REQ-004 The block SHALL have parameter NUM_SPRITES, default 4, range 1..16, number of rectangle sprites.
REQ-005 The block SHALL have parameter XYBITS, default 12, coordinate and size width.
REQ-006 The block SHALL have parameter BG_COLOR, default 0, background pixel value.
REQ-007 The block SHALL have port clk, input, 1, clock.
REQ-008 The block SHALL have port resetn, input, 1, reset; synchronous, active-low.
REQ-009 The block SHALL have port cfg_wr, input, 1, sprite config write strobe.
REQ-010 The block SHALL have port cfg_idx, input, 4, sprite index for write.
REQ-011 The block SHALL have ports cfg_x, cfg_y, cfg_w, cfg_h, input, XYBITS each, sprite origin and size.
REQ-012 The block SHALL have port cfg_color, input, SVO_BITS_PER_PIXEL, sprite colour.
REQ-013 The block SHALL have port cfg_en, input, 1, sprite enable.
REQ-014 The block SHALL have port frame_count, output, 16, completed-frame counter.
REQ-015 The block SHALL have ports out_axis_tvalid (out, 1), out_axis_tready (in, 1), out_axis_tdata (out, SVO_BITS_PER_PIXEL), out_axis_tuser (out, 1, start of frame).

Function
REQ-016 Per sprite, the block SHALL keep a pending set (written by cfg) and an active set (used for rendering).
REQ-017 On cfg_wr=1 with cfg_idx<NUM_SPRITES, the pending set of that sprite SHALL take all cfg fields on that edge; cfg_idx>=NUM_SPRITES SHALL be ignored; repeated writes within a frame: last wins.
REQ-018 The active set SHALL copy all pending sets on the edge that loads beat (H-1,V-1) into the output register; a cfg write on that same edge SHALL land in pending only and take effect one frame later.
REQ-019 Output register load SHALL occur when out_axis_tvalid=0 or out_axis_tready=1; otherwise tdata, tuser, the cursors and the active set SHALL hold.
REQ-020 Each load SHALL present beat for cursor (h,v), then advance h; at h=H-1, h->0 and v advances; at (H-1,V-1) both wrap to 0.
REQ-021 out_axis_tuser SHALL be 1 only on the beat for (0,0).
REQ-022 Sprite i SHALL cover (h,v) iff en_i and x_i<=h<x_i+w_i and y_i<=v<y_i+h_i, with sums computed in XYBITS+1 bits (no wrap); w=0 or h=0 covers nothing; clipping at screen edge is implicit.
REQ-023 If multiple sprites cover a pixel, the lowest index SHALL win; no cover yields BG_COLOR.
REQ-024 frame_count SHALL increment by 1 (mod 2^16) on each load of beat (H-1,V-1).
REQ-025 Once out_axis_tvalid is 1 it SHALL remain 1 until reset.

Reset
REQ-026 While resetn=0: out_axis_tvalid=0, out_axis_tdata=0, out_axis_tuser=0, frame_count=0, cursors=(0,0), all pending and active sets cleared (en=0).
REQ-027 The first edge with resetn=1 SHALL load beat (0,0) (tvalid=1, tuser=1, tdata=BG_COLOR); cfg writes in frame 0 first render in frame 1.
REQ-028 Reset asserted mid-frame SHALL abandon the frame; the next frame SHALL start at (0,0) with tuser=1.

Verification (H=16, V=8, NUM_SPRITES=4, tready=1 unless stated)
REQ-029 Reset release, no writes -> 128 beats all BG_COLOR, tuser only beat 0, frame_count=1 after beat 127 load.
REQ-030 Write sprite 1 x=4,y=2,w=3,h=2,color=0xFF0000,en=1 in frame 0 -> frame 0 all BG; frame 1 pixels h4..6, v2..3 = 0xFF0000, 6 pixels total.
REQ-031 Sprite 0 (0,0,8,8,0x00FF00) overlapping sprite 1 above -> overlap pixels 0x00FF00; h=7 v=2 green, h=8..? none red beyond h6.
REQ-032 Sprite 2 x=14,y=6,w=10,h=10 -> only h14..15, v6..7 coloured; no wrap to h=0 or v=0; x=4095,w=2 (XYBITS=12) draws nothing.
REQ-033 tready toggled 1/0 pseudo-randomly -> tdata/tuser stable while stalled; beat sequence identical to tready=1 run.
REQ-034 Reset pulsed at beat 50 of frame 1 -> tvalid=0 during reset, then beat (0,0) tuser=1, frame_count=0, all BG.

Source files
------------

// File: rtl/svo_sprite_gen_if.sv
// AXI4-Stream style pixel channel for the sprite generator: one pixel per beat,
// tuser marks the first pixel of a frame.
interface svo_sprite_gen_if #(
  parameter int BITS = 24
);
  logic            tvalid;
  logic            tready;
  logic [BITS-1:0] tdata;
  logic            tuser;

  modport master (output tvalid, output tdata, output tuser, input tready);
  modport slave  (input tvalid, input tdata, input tuser, output tready);
endinterface

// File: rtl/svo_sprite_gen.sv
// Rectangle sprite renderer: streams an H x V frame, painting up to NUM_SPRITES
// solid rectangles over a background colour. Sprite config is double-buffered per frame.
module svo_sprite_gen #(
  parameter int SVO_HOR_PIXELS     = 640,
  parameter int SVO_VER_PIXELS     = 480,
  parameter int SVO_BITS_PER_PIXEL = 24,
  parameter int NUM_SPRITES        = 4,
  parameter int XYBITS             = 12,
  parameter logic [SVO_BITS_PER_PIXEL-1:0] BG_COLOR = '0
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          cfg_wr,
  input  logic [3:0]                    cfg_idx,
  input  logic [XYBITS-1:0]             cfg_x,
  input  logic [XYBITS-1:0]             cfg_y,
  input  logic [XYBITS-1:0]             cfg_w,
  input  logic [XYBITS-1:0]             cfg_h,
  input  logic [SVO_BITS_PER_PIXEL-1:0] cfg_color,
  input  logic                          cfg_en,
  output logic [15:0]                   frame_count,
  svo_sprite_gen_if.master              out_axis
);

  typedef struct packed {
    logic                          en;
    logic [XYBITS-1:0]             x;
    logic [XYBITS-1:0]             y;
    logic [XYBITS-1:0]             w;
    logic [XYBITS-1:0]             h;
    logic [SVO_BITS_PER_PIXEL-1:0] color;
  } sprite_t;

  // Cursors share the coordinate width, so XYBITS must be able to hold H-1 and V-1.
  localparam logic [XYBITS-1:0] H_LAST = XYBITS'(SVO_HOR_PIXELS - 1);
  localparam logic [XYBITS-1:0] V_LAST = XYBITS'(SVO_VER_PIXELS - 1);

  sprite_t                       pending [NUM_SPRITES];
  sprite_t                       active  [NUM_SPRITES];
  logic [XYBITS-1:0]             h_cur;
  logic [XYBITS-1:0]             v_cur;
  logic [SVO_BITS_PER_PIXEL-1:0] pix;
  logic                          load;
  logic                          h_last;
  logic                          frame_last;

  // Rectangle ends are formed one bit wider so a sprite near the top of the
  // coordinate range cannot wrap around and reappear at the screen origin.
  function automatic logic covers(sprite_t s, logic [XYBITS-1:0] ph, logic [XYBITS-1:0] pv);
    logic [XYBITS:0] x_end;
    logic [XYBITS:0] y_end;
    x_end = {1'b0, s.x} + {1'b0, s.w};
    y_end = {1'b0, s.y} + {1'b0, s.h};
    return s.en && (s.x <= ph) && ({1'b0, ph} < x_end)
                && (s.y <= pv) && ({1'b0, pv} < y_end);
  endfunction

  assign load       = !out_axis.tvalid || out_axis.tready;
  assign h_last     = (h_cur == H_LAST);
  assign frame_last = h_last && (v_cur == V_LAST);

  // Walking from the highest index down lets the lowest covering sprite win.
  always_comb begin
    pix = BG_COLOR;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (covers(active[i], h_cur, v_cur)) pix = active[i].color;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_axis.tvalid <= 1'b0;
      out_axis.tdata  <= '0;
      out_axis.tuser  <= 1'b0;
      frame_count     <= '0;
      h_cur           <= '0;
      v_cur           <= '0;
      // NOTE: the sprite tables are register arrays, not RAM, and must leave
      // reset with every sprite disabled, so they are cleared here explicitly.
      for (int i = 0; i < NUM_SPRITES; i++) begin
        pending[i] <= '0;
        active[i]  <= '0;
      end
    end else begin
      if (load) begin
        out_axis.tvalid <= 1'b1;
        out_axis.tdata  <= pix;
        out_axis.tuser  <= (h_cur == '0) && (v_cur == '0);
        if (h_last) begin
          h_cur <= '0;
          v_cur <= frame_last ? '0 : v_cur + XYBITS'(1);
        end else begin
          h_cur <= h_cur + XYBITS'(1);
        end
        // NOTE: non-blocking assignment means active takes pending as it was
        // before this edge, so a cfg write on the frame's last beat waits a frame.
        if (frame_last) begin
          active      <= pending;
          frame_count <= frame_count + 16'd1;
        end
      end
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (cfg_wr && cfg_idx == 4'(i)) begin
          pending[i] <= '{en: cfg_en, x: cfg_x, y: cfg_y, w: cfg_w, h: cfg_h, color: cfg_color};
        end
      end
    end
  end

endmodule

// File: tb/tb_svo_sprite_gen.sv
// Self-checking bench for svo_sprite_gen on a 16x8 screen: per-cycle reference model
// plus a table of pixel/colour-count probes over captured frames.
module tb_svo_sprite_gen;

  localparam int H = 16;
  localparam int V = 8;
  localparam int NS = 4;
  localparam int BEATS = H * V;
  localparam logic [23:0] BG    = 24'h0A0B0C;
  localparam logic [23:0] RED   = 24'hFF0000;
  localparam logic [23:0] GREEN = 24'h00FF00;
  localparam logic [23:0] BLUE  = 24'h0000FF;
  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] CYAN  = 24'h00FFFF;
  localparam logic [23:0] GREY  = 24'h777777;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cfg_wr = 1'b0;
  logic [3:0]  cfg_idx = '0;
  logic [11:0] cfg_x = '0, cfg_y = '0, cfg_w = '0, cfg_h = '0;
  logic [23:0] cfg_color = '0;
  logic        cfg_en = 1'b0;
  logic [15:0] frame_count;

  svo_sprite_gen_if #(.BITS(24)) out_if ();

  svo_sprite_gen #(
    .SVO_HOR_PIXELS(H), .SVO_VER_PIXELS(V), .SVO_BITS_PER_PIXEL(24),
    .NUM_SPRITES(NS), .XYBITS(12), .BG_COLOR(BG)
  ) dut (
    .clk(clk), .resetn(resetn), .cfg_wr(cfg_wr), .cfg_idx(cfg_idx),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_w(cfg_w), .cfg_h(cfg_h),
    .cfg_color(cfg_color), .cfg_en(cfg_en), .frame_count(frame_count),
    .out_axis(out_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: sprite lists as plain integers, stream position as a linear beat number.
  typedef struct {
    bit          en;
    int          x, y, w, h;
    logic [23:0] c;
  } msprite_t;

  msprite_t    m_pend [NS];
  msprite_t    m_act  [NS];
  int          m_beat = 0;       // next beat to be loaded
  logic        m_valid = 1'b0;
  logic [23:0] m_data = '0;
  logic        m_user = 1'b0;
  logic [15:0] m_fc = '0;

  function automatic logic [23:0] ref_pix(input int ph, input int pv);
    for (int i = 0; i < NS; i++) begin
      if (m_act[i].en && ph >= m_act[i].x && ph < m_act[i].x + m_act[i].w &&
          pv >= m_act[i].y && pv < m_act[i].y + m_act[i].h)
        return m_act[i].c;
    end
    return BG;
  endfunction

  task automatic model_step();
    if (!resetn) begin
      m_valid = 1'b0; m_data = '0; m_user = 1'b0; m_fc = '0; m_beat = 0;
      for (int i = 0; i < NS; i++) begin
        m_pend[i] = '{0, 0, 0, 0, 0, 24'h0};
        m_act[i]  = '{0, 0, 0, 0, 0, 24'h0};
      end
    end else begin
      if (!m_valid || out_if.tready) begin
        m_data  = ref_pix(m_beat % H, m_beat / H);
        m_user  = (m_beat == 0);
        m_valid = 1'b1;
        if (m_beat == BEATS - 1) begin
          m_act = m_pend;
          m_fc  = m_fc + 16'd1;
        end
        m_beat = (m_beat + 1) % BEATS;
      end
      if (cfg_wr && int'(cfg_idx) < NS)
        m_pend[cfg_idx] = '{cfg_en, int'(cfg_x), int'(cfg_y), int'(cfg_w), int'(cfg_h), cfg_color};
    end
  endtask

  // Captured frames, built from accepted beats only (tvalid && tready at the edge).
  logic [23:0] img [6][BEATS];
  int  frame_no = -1;
  int  pos = 0;
  bit  cap_en = 1'b1;

  task automatic tick();
    if (cap_en && resetn && out_if.tvalid === 1'b1 && out_if.tready) begin
      if (out_if.tuser) begin
        frame_no++;
        pos = 0;
      end
      if (frame_no >= 0 && frame_no < 6 && pos < BEATS) img[frame_no][pos] = out_if.tdata;
      pos++;
    end
    model_step();
    @(posedge clk);
    #1;
    check("tvalid", 64'(out_if.tvalid), 64'(m_valid));
    check("tdata", 64'(out_if.tdata), 64'(m_data));
    check("tuser", 64'(out_if.tuser), 64'(m_user));
    check("frame_count", 64'(frame_count), 64'(m_fc));
  endtask

  task automatic run_to(input int f, input int b);
    int n = 0;
    while (!(m_fc == 16'(f) && m_beat == b)) begin
      tick();
      n++;
      if (n > 5000) begin
        n_checks++;
        n_fail++;
        $display("FAIL run_to_budget: frame %0d beat %0d not reached", f, b);
        break;
      end
    end
  endtask

  task automatic cfg_write(input int idx, input int x, input int y, input int w, input int h,
                           input logic [23:0] c, input bit en);
    cfg_wr = 1'b1; cfg_idx = 4'(idx);
    cfg_x = 12'(x); cfg_y = 12'(y); cfg_w = 12'(w); cfg_h = 12'(h);
    cfg_color = c; cfg_en = en;
    tick();
    cfg_wr = 1'b0;
  endtask

  function automatic int count_color(input int f, input logic [23:0] c);
    int n = 0;
    for (int i = 0; i < BEATS; i++) if (img[f][i] === c) n++;
    return n;
  endfunction

  typedef enum {PIX, CNT} kind_t;
  typedef struct {
    kind_t       kind;
    int          frame;
    int          h, v;       // pixel probe position (PIX)
    logic [23:0] color;      // expected pixel, or colour to count
    int          count;      // expected count (CNT)
  } probe_t;

  probe_t probes [$];

  initial begin
    // Frame 0: nothing enabled yet. Frame 1: red sprite 1 only.
    // Frame 2..3: green sprite 0 over red, blue clipped sprite 2, offscreen sprite 3.
    // Frame 4: grey sprite 3 written on frame 2's last beat. Frame 5: first frame after reset.
    probes = '{
      '{CNT, 0, 0, 0, BG, 128},
      '{PIX, 0, 0, 0, BG, 0},
      '{CNT, 1, 0, 0, RED, 6},
      '{CNT, 1, 0, 0, CYAN, 0},
      '{PIX, 1, 4, 2, RED, 0},
      '{PIX, 1, 6, 3, RED, 0},
      '{PIX, 1, 7, 2, BG, 0},
      '{PIX, 1, 3, 2, BG, 0},
      '{PIX, 1, 4, 4, BG, 0},
      '{PIX, 2, 4, 2, GREEN, 0},
      '{PIX, 2, 7, 2, GREEN, 0},
      '{PIX, 2, 8, 2, BG, 0},
      '{CNT, 2, 0, 0, RED, 0},
      '{CNT, 2, 0, 0, GREEN, 64},
      '{CNT, 2, 0, 0, BLUE, 4},
      '{CNT, 2, 0, 0, WHITE, 0},
      '{PIX, 2, 14, 6, BLUE, 0},
      '{PIX, 2, 15, 7, BLUE, 0},
      '{PIX, 2, 13, 6, BG, 0},
      '{PIX, 2, 15, 0, BG, 0},
      '{PIX, 3, 15, 0, BG, 0},
      '{CNT, 3, 0, 0, GREEN, 64},
      '{CNT, 3, 0, 0, GREY, 0},
      '{PIX, 4, 15, 0, GREY, 0},
      '{CNT, 4, 0, 0, GREEN, 64},
      '{CNT, 4, 0, 0, BLUE, 4},
      '{CNT, 5, 0, 0, BG, 128}
    };

    out_if.tready = 1'b1;
    resetn = 1'b0;
    repeat (3) tick();
    check("rst_tvalid", 64'(out_if.tvalid), 64'd0);

    resetn = 1'b1;
    tick();
    check("sof_tuser", 64'(out_if.tuser), 64'd1);
    check("sof_tdata", 64'(out_if.tdata), 64'(BG));

    // Frame 0 writes, including an out-of-range index that must be dropped.
    run_to(0, 10);
    cfg_write(1, 4, 2, 3, 2, RED, 1'b1);
    cfg_write(5, 0, 0, 16, 8, CYAN, 1'b1);

    run_to(1, 20);
    cfg_write(0, 0, 0, 8, 8, GREEN, 1'b1);
    cfg_write(2, 14, 6, 10, 10, BLUE, 1'b1);
    cfg_write(3, 4095, 0, 2, 8, WHITE, 1'b1);

    // Write on the very edge that loads the last beat of frame 2.
    run_to(2, BEATS - 1);
    cfg_write(3, 15, 0, 1, 1, GREY, 1'b1);

    // Frames 3 and 4 under random backpressure.
    begin
      int n = 0;
      while (!(m_fc == 16'd5 && m_beat == 0) && n < 4000) begin
        out_if.tready = 1'($urandom_range(0, 1));
        tick();
        n++;
      end
      check("stall_phase_done", 64'(m_fc), 64'd5);
      out_if.tready = 1'b1;
      tick();
      cap_en = 1'b0;
    end

    // Random config traffic and backpressure against the reference model.
    begin
      int n = 0;
      while (m_fc != 16'd8 && n < 6000) begin
        out_if.tready = 1'($urandom_range(0, 1));
        cfg_wr = ($urandom_range(0, 7) == 0);
        cfg_idx = 4'($urandom_range(0, 5));
        cfg_x = ($urandom_range(0, 9) == 0) ? 12'd4094 : 12'($urandom_range(0, 18));
        cfg_y = 12'($urandom_range(0, 10));
        cfg_w = 12'($urandom_range(0, 8));
        cfg_h = 12'($urandom_range(0, 5));
        cfg_color = 24'($urandom);
        cfg_en = 1'($urandom_range(0, 1));
        tick();
        n++;
      end
      check("random_phase_done", 64'(m_fc), 64'd8);
      cfg_wr = 1'b0;
      out_if.tready = 1'b1;
    end

    // Reset mid-frame at beat 50.
    run_to(9, 50);
    resetn = 1'b0;
    tick();
    check("midrst_tvalid", 64'(out_if.tvalid), 64'd0);
    tick();
    resetn = 1'b1;
    cap_en = 1'b1;
    frame_no = 4;
    tick();
    check("midrst_tuser", 64'(out_if.tuser), 64'd1);
    check("midrst_fc", 64'(frame_count), 64'd0);
    run_to(1, 0);
    tick();

    foreach (probes[k]) begin
      if (probes[k].kind == PIX)
        check($sformatf("probe%0d_f%0d_h%0d_v%0d", k, probes[k].frame, probes[k].h, probes[k].v),
              64'(img[probes[k].frame][probes[k].v * H + probes[k].h]), 64'(probes[k].color));
      else
        check($sformatf("probe%0d_f%0d_count_%0h", k, probes[k].frame, probes[k].color),
              64'(count_color(probes[k].frame, probes[k].color)), 64'(probes[k].count));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
